i2c_sensor_rx: RTL

Passive I2C receive front end for the Kalman filter ASIC. It listens on the scl/sda pins to the accelerometer, gyroscope and magnetometer read bursts. It captures each 6-byte sensor frame and assembles one complete acc/gyro/mag sample set for the downstream filter datapath. It never drives sda: the external master generates every ack/nack slot.

---
 rtl/kalman_pkg.sv | 25 ++
 rtl/i2c_line_sync.sv | 61 ++++++
 rtl/i2c_sensor_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman filter sensor receive path.
package kalman_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    GYRO = 2'd1,
    MAG  = 2'd2
  } sensor_id_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT
  } rx_state_t;

  localparam logic [6:0] ACC_ADDR_DEF  = 7'h78;
  localparam logic [6:0] GYRO_ADDR_DEF = 7'h79;
  localparam logic [6:0] MAG_ADDR_DEF  = 7'h7A;

  localparam int FRAME_BYTES = 6;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings raw scl/sda into the clk domain and produces registered edge,
// START and STOP pulses that are all aligned with the sampled sda level.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic rise_q, fall_q, start_q, stop_q;
  logic rise_d, fall_d, start_d, stop_d;

  always_comb begin
    rise_d  = scl_sync_q & ~scl_prev_q;
    fall_d  = ~scl_sync_q & scl_prev_q;
    // sda edges only count as bus conditions while scl is stable high
    start_d = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    stop_d  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Lines idle high, so preset to 1 to avoid phantom edges after reset
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign sda_s     = sda_prev_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_sensor_rx.sv
// Passive I2C listener: captures 6-byte sensor frames and assembles
// acc/gyro/mag sample sets for the filter datapath.
module i2c_sensor_rx
  import kalman_pkg::*;
#(
  parameter logic [6:0] ACC_ADDR  = ACC_ADDR_DEF,
  parameter logic [6:0] GYRO_ADDR = GYRO_ADDR_DEF,
  parameter logic [6:0] MAG_ADDR  = MAG_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        frame_valid,
  output logic [1:0]  frame_id,
  output logic [47:0] frame_data,
  output logic        set_valid,
  output logic [47:0] acc_data,
  output logic [47:0] gyro_data,
  output logic [47:0] mag_data,
  output logic        frame_error
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  rx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [47:0] shift_q, shift_d;
  sensor_id_t  id_q, id_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_error_q, frame_error_d;
  sensor_id_t  frame_id_q, frame_id_d;
  logic [47:0] frame_data_q, frame_data_d;
  logic [2:0]  mask_q, mask_d;
  logic [47:0] acc_sh_q, acc_sh_d, gyro_sh_q, gyro_sh_d, mag_sh_q, mag_sh_d;
  logic        set_valid_q, set_valid_d;
  logic [47:0] acc_q, acc_d, gyro_q, gyro_d, mag_q, mag_d;
  logic        in_frame;

  // scl_fall and the bit shifted out of the top are not needed here
  logic unused_sigs;
  assign unused_sigs = scl_fall ^ shift_q[47];

  assign in_frame = (state_q == ADDR) || (state_q == ADDR_ACK) ||
                    (state_q == DATA) || (state_q == DATA_ACK);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    id_d          = id_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    frame_id_d    = frame_id_q;
    frame_data_d  = frame_data_q;

    // Bus conditions win over a coincident scl_rise; that bit is dropped
    if (start_det) begin
      frame_error_d = in_frame;
      state_d       = ADDR;
      bit_cnt_d     = 3'd0;
      byte_cnt_d    = 3'd0;
    end else if (stop_det) begin
      frame_error_d = in_frame;
      state_d       = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        ADDR: begin
          shift_d   = {shift_q[46:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // shift_q[6:0] holds address bits; the bit arriving now is R/W
            if (shift_q[6:0] == ACC_ADDR) begin
              id_d    = ACC;
              state_d = ADDR_ACK;
            end else if (shift_q[6:0] == GYRO_ADDR) begin
              id_d    = GYRO;
              state_d = ADDR_ACK;
            end else if (shift_q[6:0] == MAG_ADDR) begin
              id_d    = MAG;
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT;
            end
          end
        end
        ADDR_ACK: begin
          state_d    = DATA;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d   = {shift_q[46:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = DATA_ACK;
            if (byte_cnt_q == LAST_BYTE) begin
              frame_valid_d = 1'b1;
              frame_id_d    = id_q;
              frame_data_d  = shift_d;
            end
          end
        end
        DATA_ACK: begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = WAIT;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadows are written alongside frame_valid so a completed mask is seen
  // while frame_valid is high and set_valid follows one cycle later.
  always_comb begin
    mask_d      = mask_q;
    acc_sh_d    = acc_sh_q;
    gyro_sh_d   = gyro_sh_q;
    mag_sh_d    = mag_sh_q;
    set_valid_d = 1'b0;
    acc_d       = acc_q;
    gyro_d      = gyro_q;
    mag_d       = mag_q;

    if (mask_q == 3'b111) begin
      set_valid_d = 1'b1;
      acc_d       = acc_sh_q;
      gyro_d      = gyro_sh_q;
      mag_d       = mag_sh_q;
      mask_d      = 3'b000;
    end

    if (frame_valid_d) begin
      case (id_q)
        ACC: begin
          acc_sh_d  = frame_data_d;
          mask_d[0] = 1'b1;
        end
        GYRO: begin
          gyro_sh_d = frame_data_d;
          mask_d[1] = 1'b1;
        end
        MAG: begin
          mag_sh_d  = frame_data_d;
          mask_d[2] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 3'd0;
      shift_q       <= '0;
      id_q          <= ACC;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_id_q    <= ACC;
      frame_data_q  <= '0;
      mask_q        <= 3'b000;
      acc_sh_q      <= '0;
      gyro_sh_q     <= '0;
      mag_sh_q      <= '0;
      set_valid_q   <= 1'b0;
      acc_q         <= '0;
      gyro_q        <= '0;
      mag_q         <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      id_q          <= id_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      frame_id_q    <= frame_id_d;
      frame_data_q  <= frame_data_d;
      mask_q        <= mask_d;
      acc_sh_q      <= acc_sh_d;
      gyro_sh_q     <= gyro_sh_d;
      mag_sh_q      <= mag_sh_d;
      set_valid_q   <= set_valid_d;
      acc_q         <= acc_d;
      gyro_q        <= gyro_d;
      mag_q         <= mag_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_id    = frame_id_q;
  assign frame_data  = frame_data_q;
  assign frame_error = frame_error_q;
  assign set_valid   = set_valid_q;
  assign acc_data    = acc_q;
  assign gyro_data   = gyro_q;
  assign mag_data    = mag_q;

endmodule
